// File: rtl/rv32i_decode_pipe.sv
// rv32i_decode_pipe: registered RV32I decode stage with output FIFO and halt/trap FSM
module rv32i_decode_pipe #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 2,
    parameter int ALUOP_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instruction,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALUOP_W-1:0] ALU_op_d,
    output logic [2:0]         immsel,
    output logic [XLEN-1:0]    imm,
    output logic [4:0]         rd,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic               halt,
    output logic               illegal,
    output logic               halted,
    input  logic               resume
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [ALUOP_W-1:0] op;
        logic [2:0]         sel;
        logic [XLEN-1:0]    imm;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic               halt;
        logic               ill;
    } rec_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [4:0]        op5;
    logic [4:0]        alu5;
    logic [2:0]        sel;
    logic              hlt;
    logic              ill;
    logic signed [31:0] imm32;
    rec_t              dec;
    rec_t              head;
    rec_t              mem_q [DEPTH];
    rec_t              mem_d [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    state_t            state_q, state_d;
    logic              push;
    logic              pop;

    assign opc = instruction[6:0];
    assign f3  = instruction[14:12];
    assign f7  = instruction[31:25];

    // Arithmetic op from funct3; bit 30 picks SUB only for register form, SRA for both
    always_comb begin
        alu5 = 5'd0;
        case (f3)
            3'b000:  alu5 = (opc[5] && instruction[30]) ? 5'd3 : 5'd2;
            3'b001:  alu5 = 5'd4;
            3'b010:  alu5 = 5'd5;
            3'b011:  alu5 = 5'd6;
            3'b100:  alu5 = 5'd7;
            3'b101:  alu5 = instruction[30] ? 5'd9 : 5'd8;
            3'b110:  alu5 = 5'd10;
            default: alu5 = 5'd11;
        endcase
    end

    // Opcode decode into op, immediate format, halt and illegal flags
    always_comb begin
        op5 = 5'd0;
        sel = 3'd0;
        hlt = 1'b0;
        ill = 1'b0;
        case (opc)
            7'b0110111: begin op5 = 5'd1; sel = 3'd4; end
            7'b0010111: begin op5 = 5'd2; sel = 3'd4; end
            7'b1101111: begin op5 = 5'd2; sel = 3'd5; end
            7'b1100111,
            7'b0000011: begin op5 = 5'd2; sel = 3'd1; end
            7'b0100011: begin op5 = 5'd2; sel = 3'd2; end
            7'b1100011: begin
                sel = 3'd3;
                op5 = f3[2] ? 5'd14 + {3'b0, f3[1:0]} : f3[1] ? 5'd0 : 5'd12 + {4'b0, f3[0]};
            end
            7'b0010011: begin op5 = alu5; sel = 3'd1; end
            7'b0110011: begin
                ill = f7 != 7'b0000000 && f7 != 7'b0100000;
                op5 = ill ? 5'd0 : alu5;
            end
            7'b0001111: ;
            7'b1110011: begin
                hlt = f3 == 3'b000;
                sel = hlt ? 3'd1 : 3'd0;
            end
            default: ill = 1'b1;
        endcase
    end

    // Immediate assembly per format, then sign-extend to XLEN
    always_comb begin
        imm32 = sel == 3'd1 ? {{20{instruction[31]}}, instruction[31:20]} :
                sel == 3'd2 ? {{20{instruction[31]}}, instruction[31:25], instruction[11:7]} :
                sel == 3'd3 ? {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0} :
                sel == 3'd4 ? {instruction[31:12], 12'b0} :
                sel == 3'd5 ? {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0} :
                32'sd0;
        dec      = '0;
        dec.op   = ALUOP_W'(op5);
        dec.sel  = sel;
        dec.imm  = XLEN'(imm32);
        dec.rd   = instruction[11:7];
        dec.rs1  = instruction[19:15];
        dec.rs2  = instruction[24:20];
        dec.halt = hlt;
        dec.ill  = ill;
    end

    assign in_ready  = state_q == RUN && count_q != (AW+1)'(DEPTH);
    assign out_valid = count_q != '0;
    assign halted    = state_q == HALTED;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // FIFO write, pointer and occupancy update
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q[AW-1:0]] = dec;
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Next state: halt/illegal drains the buffer, then waits for resume
    always_comb begin
        state_d = (state_q == RUN && push && (hlt || ill)) ? DRAIN :
                  (state_q == DRAIN && count_d == '0)     ? HALTED :
                  (state_q == HALTED && resume)           ? RUN :
                  state_q;
    end

    // State, pointers and buffer storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign head     = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign ALU_op_d = head.op;
    assign immsel   = head.sel;
    assign imm      = head.imm;
    assign rd       = head.rd;
    assign rs1      = head.rs1;
    assign rs2      = head.rs2;
    assign halt     = head.halt;
    assign illegal  = head.ill;
endmodule

// File: tb/tb_rv32i_decode_pipe.sv
// tb_rv32i_decode_pipe: scoreboard bench for the decode stage with directed vectors
module tb_rv32i_decode_pipe;
    typedef struct packed {
        logic [4:0]  op;
        logic [2:0]  sel;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        halt;
        logic        ill;
    } rec_t;

    logic        clk = 0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alu_op;
    logic [2:0]  immsel;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic        halt, illegal, halted, resume;

    int   n_pass = 0;
    int   n_total = 0;
    rec_t exp_q[$];
    rec_t got;

    rv32i_decode_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
        .ALU_op_d(alu_op), .immsel(immsel), .imm(imm), .rd(rd), .rs1(rs1), .rs2(rs2),
        .halt(halt), .illegal(illegal), .halted(halted), .resume(resume)
    );

    always #5 clk = ~clk;

    assign got = {alu_op, immsel, imm, rd, rs1, rs2, halt, illegal};

    function automatic rec_t mk(input int op, input int sel, input logic [31:0] im,
                                input int d, input int s1, input int s2, input bit h, input bit il);
        mk = {5'(op), 3'(sel), im, 5'(d), 5'(s1), 5'(s2), h, il};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act !== req) $display("FAIL %s: got %h expected %h", name, act, req);
        else n_pass++;
    endtask

    // Monitor: every record taken by the consumer must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_record", 128'(got), 128'(0));
            else check("record", 128'(got), 128'(exp_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] ins, input rec_t e);
        int n = 0;
        in_valid = 1'b1;
        instruction = ins;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_timeout", 128'(in_ready), 128'(1));
        else exp_q.push_back(e);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 128'(exp_q.size()), 128'(0));
        step();
    endtask

    task automatic wait_halted();
        int n = 0;
        @(negedge clk);
        while (!halted && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("halted_set", 128'(halted), 128'(1));
        step();
    endtask

    task automatic pulse_resume();
        resume = 1'b1;
        step();
        resume = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; resume = 1'b0; instruction = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_halted", 128'(halted), 128'(0));
        check("rst_record", 128'(got), 128'(0));
        step();

        out_ready = 1'b1;
        push(32'h00638133, mk(2, 0, 32'h0, 2, 7, 6, 0, 0));
        @(negedge clk);
        check("latency_valid", 128'(out_valid), 128'(1));
        step();
        push(32'h0180006F, mk(2, 5, 32'd24, 0, 0, 24, 0, 0));
        push(32'h00639063, mk(13, 3, 32'h0, 0, 7, 6, 0, 0));
        push(32'hFFF00093, mk(2, 1, 32'hFFFFFFFF, 1, 0, 31, 0, 0));
        push(32'h40638133, mk(3, 0, 32'h0, 2, 7, 6, 0, 0));
        push(32'h4030D093, mk(9, 1, 32'h403, 1, 1, 3, 0, 0));
        push(32'h123450B7, mk(1, 4, 32'h12345000, 1, 8, 3, 0, 0));
        push(32'h00112423, mk(2, 2, 32'd8, 8, 2, 1, 0, 0));
        push(32'hFE000EE3, mk(12, 3, 32'hFFFFFFFC, 29, 0, 0, 0, 0));
        wait_empty();

        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            instruction = 32'h00000093 | (32'(i) << 20);
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(mk(2, 1, 32'(i), 1, 0, i, 0, 0));
                acc++;
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("full_accepted", 128'(acc), 128'(2));
        check("full_in_ready", 128'(in_ready), 128'(0));
        check("hold_head0", 128'(got), 128'(exp_q[0]));
        @(negedge clk);
        check("hold_head1", 128'(got), 128'(exp_q[0]));
        step();
        out_ready = 1'b1;
        for (int i = 10; i < 15; i++)
            push(32'h00000093 | (32'(i) << 20), mk(2, 1, 32'(i), 1, 0, i, 0, 0));
        wait_empty();

        out_ready = 1'b0;
        push(32'h00000073, mk(0, 1, 32'h0, 0, 0, 0, 1, 0));
        @(negedge clk);
        check("halt_head", 128'(halt), 128'(1));
        check("halt_in_ready", 128'(in_ready), 128'(0));
        step();
        out_ready = 1'b1;
        wait_halted();
        in_valid = 1'b1;
        instruction = 32'h00638133;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halted_in_ready", 128'(in_ready), 128'(0));
            check("halted_no_out", 128'(out_valid), 128'(0));
            step();
        end
        in_valid = 1'b0;
        pulse_resume();
        @(negedge clk);
        check("resume_in_ready", 128'(in_ready), 128'(1));
        check("resume_halted", 128'(halted), 128'(0));
        step();

        out_ready = 1'b0;
        push(32'h0000007F, mk(0, 0, 32'h0, 0, 0, 0, 0, 1));
        @(negedge clk);
        check("illegal_head", 128'(illegal), 128'(1));
        step();
        pulse_resume();
        @(negedge clk);
        check("drain_ignores_resume", 128'(halted), 128'(0));
        check("drain_in_ready", 128'(in_ready), 128'(0));
        check("drain_out_valid", 128'(out_valid), 128'(1));
        step();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 128'(out_valid), 128'(0));
        check("async_rst_halted", 128'(halted), 128'(0));
        exp_q.delete();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 128'(in_ready), 128'(1));
        step();

        out_ready = 1'b1;
        push(32'h02638133, mk(0, 0, 32'h0, 2, 7, 6, 0, 1));
        wait_halted();
        pulse_resume();
        push(32'h00638133, mk(2, 0, 32'h0, 2, 7, 6, 0, 0));
        wait_empty();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rv32i_decode_pipe.md
# rv32i_decode_pipe

Registered, flow-controlled RV32I instruction decode stage with a parametrised output buffer and a halt/trap state machine. It sits between the fetch stage and the register-read/execute stage. Each accepted instruction becomes one decoded record: ALU op, immediate select, sign-extended immediate, register indices, halt and illegal flags. It generalises the earlier combinational DECODER with valid/ready handshakes, buffering, a sticky halt and illegal-opcode detection.

## Interface
- XLEN, 32: immediate output width; must be ≥ 32.
- DEPTH, 2: output buffer entries; power of two, ≥ 2.
- ALUOP_W, 5: ALU op width; must be ≥ 5.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage accepts instruction this cycle.
- instruction  in  32  raw RV32I word.
- out_valid  out  1  decoded record at buffer head.
- out_ready  in  1  consumer takes head record.
- ALU_op_d  out  ALUOP_W  ALU operation code.
- immsel  out  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
- imm  out  XLEN  sign-extended immediate (U: instr[31:12]<<12); 0 when immsel = 0.
- rd, rs1, rs2  out  5 each  instr[11:7], [19:15], [24:20]; unused fields still output raw bits.
- halt  out  1  head record is a halt instruction.
- illegal  out  1  head record has an unsupported opcode/funct.
- halted  out  1  state machine is in HALTED.
- resume  in  1  single-cycle pulse; leaves HALTED.

## Operation
- ALU_op_d codes:
  - 0 NOP/illegal; 1 LUI pass-B.
  - 2 ADD: ADD, ADDI, all loads, all stores, JAL, JALR, AUIPC.
  - 3 SUB, 4 SLL, 5 SLT, 6 SLTU, 7 XOR, 8 SRL, 9 SRA, 10 OR, 11 AND (R and I forms).
  - 12 BEQ, 13 BNE, 14 BLT, 15 BGE, 16 BLTU, 17 BGEU.
- Halt: opcode 1110011 with funct3 000 (ECALL/EBREAK). Gives halt=1, ALU_op_d=0, immsel=1.
- Illegal: any opcode outside the RV32I base set (FENCE 0001111 is decoded as NOP, legal), or R-type funct7 not in {0000000, 0100000}. Gives illegal=1, ALU_op_d=0, immsel=0, imm=0.
- Buffer: circular FIFO of DEPTH records. Write pointer, read pointer and count are log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
- State machine:
  - RUN: in_ready = !full.
  - Accepting a halt or illegal word moves to DRAIN. in_ready = 0 from the next cycle.
  - DRAIN moves to HALTED when the buffer empties (the halt/illegal record has been consumed).
  - HALTED: in_ready = 0, halted = 1. resume moves to RUN next cycle.
  - resume is ignored in RUN and DRAIN.

## Timing
- Reset (asynchronous assert, synchronous-safe release): state RUN, FIFO empty.
  - out_valid=0, in_ready=1 (once rst_n is high), halted=0.
  - All record outputs 0.
- Latency: a word accepted at edge N is at the head with out_valid=1 after edge N if the FIFO was empty. Otherwise it appears behind older records, in order.
- Throughput: one record per cycle when out_ready is held at 1.
- Full: in_ready=0. A simultaneous pop while full does not raise in_ready in the same cycle; in_ready is a function of registered state only.
- Empty with push: out_valid rises the next cycle; no combinational bypass.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Outputs hold stable while out_valid=1 and out_ready=0.
- rst_n asserted mid-operation: buffered records are discarded and state returns to RUN asynchronously.

## Test plan
- Reset, then push 0x00638133 (ADD x2,x7,x6) with out_ready=1 -> one cycle later out_valid=1, ALU_op_d=2, immsel=0, rd=2, rs1=7, rs2=6.
- Push 0x0000006F... with imm bits set: 0x0180006F (JAL x0,+24) -> ALU_op_d=2, immsel=5, imm=24. Then 0x00639063 (BNE x7,x6,0) -> ALU_op_d=13, immsel=3, imm=0.
- Push 0xFFF00093 (ADDI x1,x0,-1) -> immsel=1, imm=0xFFFFFFFF.
- out_ready=0 with continuous pushes -> exactly DEPTH records accepted, then in_ready=0. Release out_ready -> records emerge in order, with no loss or duplication across pointer wrap.
- Push 0x00000073 -> halt=1 at head, in_ready=0. After the pop, halted=1. Further pushes are ignored. A resume pulse gives in_ready=1 and halted=0 the next cycle.
- Push 0x0000007F -> illegal=1, ALU_op_d=0, enters DRAIN/HALTED. Asserting rst_n low mid-DRAIN clears out_valid and halted immediately.
